mem_access_unit: RTL and testbench

- Sits between the multicycle Control FSM and the external instruction/data memory bus.
- Turns Control's level MemRead/MemWrite strobes into one bus transaction each, with a req/ack handshake and a timeout.
- Returns read data (to IR/MDR) plus a one-cycle completion pulse, so the Control FSM can stall in memory states until MemDone.

---
 rtl/mem_pkg.sv | 18 +
 rtl/mem_wait_counter.sv | 30 +++
 rtl/mem_access_unit.sv | 135 +++++++++++++
 tb/tb_mem_access_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory access unit.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE,
        ERR
    } mem_state_t;

    localparam int         WORD_BYTES = 4;
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return (addr_lsb & ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Counts REQ cycles from zero; expired flags the last permitted wait cycle.
module mem_wait_counter #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int              CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // Holds at LAST so the count can never wrap even if REQ lingers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != LAST)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/mem_access_unit.sv
// Converts level MemRead/MemWrite strobes into single req/ack bus transactions
// with timeout, returning read data and a one-cycle MemDone pulse.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for an armed strobe; latches address/data on accept
//   REQ   | bus_req high, waiting for bus_ack or wait-counter expiry
//   DONE  | successful completion, MemDone for one cycle
//   ERR   | misaligned, conflicting strobes or timeout; MemDone+MemError
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData,
    output logic              MemDone,
    output logic              MemBusy,
    output logic              MemError,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-3:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack
);

    localparam int LSB = $clog2(WORD_BYTES);

    mem_state_t state, state_nxt;

    logic              armed;
    logic              accept;
    logic              expired;
    logic [ADDR_W-1:LSB] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    assign accept = (state == IDLE) && armed && (MemRead || MemWrite);

    mem_wait_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_wait (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (state != REQ),
        .en      (state == REQ),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if ((MemRead && MemWrite) || is_misaligned(Address[1:0])) begin
                        state_nxt = ERR;
                    end else begin
                        state_nxt = REQ;
                    end
                end
            end
            // Ack wins over expiry on the final wait cycle.
            REQ: begin
                if (bus_ack) begin
                    state_nxt = DONE;
                end else if (expired) begin
                    state_nxt = ERR;
                end
            end
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus_req = (state == REQ);
        MemDone = (state == DONE) || (state == ERR);
        MemBusy = (state != IDLE);
    end

    // armed re-arms only once both strobes have been seen low, so a strobe
    // still held after MemDone cannot start a second transaction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed   <= 1'b1;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                armed   <= 1'b0;
                addr_q  <= Address[ADDR_W-1:LSB];
                we_q    <= MemWrite;
                wdata_q <= WriteData;
                err_q   <= (state_nxt == ERR);
            end else if (!MemRead && !MemWrite) begin
                armed <= 1'b1;
            end
            if ((state == REQ) && bus_ack && !we_q) begin
                rdata_q <= bus_rdata;
            end
            if ((state == REQ) && !bus_ack && expired) begin
                err_q <= 1'b1;
            end
        end
    end

    assign ReadData  = rdata_q;
    assign MemError  = err_q;
    assign bus_addr  = addr_q;
    assign bus_we    = we_q;
    assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench: driver pushes expected outcomes, monitors pop on MemDone
// and check bus-side fields on every REQ cycle.
module tb_mem_access_unit;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          MemRead, MemWrite;
    logic [AW-1:0] Address;
    logic [DW-1:0] WriteData;
    logic [DW-1:0] ReadData;
    logic          MemDone, MemBusy, MemError;
    logic          bus_req, bus_we;
    logic [AW-3:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic [DW-1:0] bus_rdata;
    logic          bus_ack;

    mem_access_unit #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Address   (Address),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .MemDone   (MemDone),
        .MemBusy   (MemBusy),
        .MemError  (MemError),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          bus_cycles;
        int          done_cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [29:0] bus_exp_addr;
    logic        bus_exp_we;
    logic [31:0] bus_exp_wdata;
    logic        bus_exp_valid = 1'b0;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          ack_delay = 0;
    logic [31:0] ack_rdata = '0;
    int          req_cycles = 0;
    int          done_cnt = 0;
    logic        sticky_err = 1'b0;
    logic [31:0] mdl_rdata = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Bus responder and bus-side monitor.
    always @(negedge clk) begin
        if (bus_req) begin
            req_cycles++;
            check("bus_req_allowed", {63'd0, bus_req}, {63'd0, bus_exp_valid});
            if (bus_exp_valid) begin
                check("bus_addr", {34'd0, bus_addr}, {34'd0, bus_exp_addr});
                check("bus_we", {63'd0, bus_we}, {63'd0, bus_exp_we});
                if (bus_exp_we) check("bus_wdata", {32'd0, bus_wdata}, {32'd0, bus_exp_wdata});
            end
            bus_ack   = (req_cycles == ack_delay + 1);
            bus_rdata = bus_ack ? ack_rdata : $urandom;
        end else begin
            bus_ack   = ($urandom_range(0, 3) == 0);
            bus_rdata = $urandom;
        end
    end

    // Completion monitor.
    always @(negedge clk) begin
        if (reset_n) begin
            if (MemDone) begin
                if (exp_q.size() == 0) begin
                    check("memdone_unexpected", {63'd0, MemDone}, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("MemError", {63'd0, MemError}, {63'd0, e.err});
                    check("ReadData", {32'd0, ReadData}, {32'd0, e.rdata});
                    check("bus_cycles", 64'(req_cycles), 64'(e.bus_cycles));
                    check("done_latency", 64'(cyc), 64'(e.done_cyc));
                    sticky_err    = e.err;
                    bus_exp_valid = 1'b0;
                    done_cnt++;
                end
            end else if (!MemBusy) begin
                check("MemError_sticky", {63'd0, MemError}, {63'd0, sticky_err});
            end
        end
    end

    task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int delay,
                         input logic [31:0] rdata, input int hold);
        exp_t e;
        logic err_imm, tmo;
        int   start, off;
        bit   seen;
        @(negedge clk);
        err_imm = (rd && wr) || (addr[1:0] != 2'b00);
        tmo     = !err_imm && (delay >= TO);
        off     = err_imm ? 0 : (tmo ? TO : delay + 1);
        if (!err_imm && !tmo && rd && !wr) mdl_rdata = rdata;
        e.err        = err_imm || tmo;
        e.rdata      = mdl_rdata;
        e.bus_cycles = off;
        e.done_cyc   = cyc + 1 + off;
        exp_q.push_back(e);
        bus_exp_addr  = addr[31:2];
        bus_exp_we    = wr;
        bus_exp_wdata = wdata;
        bus_exp_valid = !err_imm;
        ack_delay     = delay;
        ack_rdata     = rdata;
        req_cycles    = 0;
        start         = done_cnt;
        MemRead       = rd;
        MemWrite      = wr;
        Address       = addr;
        WriteData     = wdata;
        seen          = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done_cnt != start) begin
                seen = 1;
                break;
            end
            Address   = $urandom;
            WriteData = $urandom;
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_wait: no MemDone within 100 cycles (cycle %0d)", cyc);
            exp_q.delete();
        end
        repeat (hold) @(negedge clk);
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic        rd, wr;
        logic [31:0] a;
        int          d;
        reset_n   = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        Address   = '0;
        WriteData = '0;
        repeat (3) @(negedge clk);
        check("rst_bus_req", {63'd0, bus_req}, 64'd0);
        check("rst_MemBusy", {63'd0, MemBusy}, 64'd0);
        check("rst_MemDone", {63'd0, MemDone}, 64'd0);
        check("rst_ReadData", {32'd0, ReadData}, 64'd0);
        check("rst_bus_addr", {34'd0, bus_addr}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        issue(1, 0, 32'h0000_0010, 32'h0, 0, 32'hDEAD_BEEF, 0);
        issue(0, 1, 32'h0000_0020, 32'h1234_5678, 3, 32'h0, 0);
        issue(1, 0, 32'h0000_0040, 32'h0, 1, 32'hA5A5_0001, 5);
        issue(1, 0, 32'h0000_0044, 32'h0, 0, 32'h5A5A_0002, 0);
        issue(1, 0, 32'h0000_0013, 32'h0, 0, 32'h0, 2);
        issue(0, 1, 32'h0000_0048, 32'hCAFE_0003, 2, 32'h0, 0);
        issue(1, 1, 32'h0000_0050, 32'h0, 0, 32'h0, 0);
        issue(1, 0, 32'h0000_0060, 32'h0, 1000, 32'h0, 0);
        issue(1, 0, 32'h0000_0064, 32'h0, TO - 1, 32'h1111_2222, 0);

        for (int n = 0; n < 150; n++) begin
            rd = 1'($urandom_range(0, 1));
            wr = !rd;
            if ($urandom_range(0, 9) == 0) begin
                rd = 1'b1;
                wr = 1'b1;
            end
            a = $urandom;
            if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
            d = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 2, TO + 2) : $urandom_range(0, 5);
            issue(rd, wr, a, $urandom, d, $urandom, $urandom_range(0, 3));
        end

        // Reset in the middle of a REQ wait.
        @(negedge clk);
        bus_exp_addr  = 30'h20;
        bus_exp_we    = 1'b0;
        bus_exp_wdata = '0;
        bus_exp_valid = 1'b1;
        ack_delay     = 1000;
        req_cycles    = 0;
        MemRead       = 1'b1;
        Address       = 32'h0000_0080;
        repeat (4) @(negedge clk);
        check("pre_rst_bus_req", {63'd0, bus_req}, 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_bus_req", {63'd0, bus_req}, 64'd0);
        check("midrst_MemBusy", {63'd0, MemBusy}, 64'd0);
        check("midrst_MemError", {63'd0, MemError}, 64'd0);
        check("midrst_ReadData", {32'd0, ReadData}, 64'd0);
        check("midrst_bus_addr", {34'd0, bus_addr}, 64'd0);
        MemRead       = 1'b0;
        bus_exp_valid = 1'b0;
        sticky_err    = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
